// File: rtl/piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer
//
// Parallel-in/serial-out stage feeding the Moore "110" sequence detector.
// A WIDTH-bit word is taken through a valid/ready handshake and sent out one
// bit per clock on serial_out. An optional idle gap can follow each frame, and
// a wrapping count of completed frames is kept for debug.
//
// Handshake: a word is accepted on the rising edge where
// load_valid && load_ready. While load_ready is low the source must hold
// data_in/load_valid; nothing is captured. load_ready is decoded from
// registered state only, so it never depends on load_valid.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous reset, active-high
//   data_in     parallel word to serialize (WIDTH bits)
//   load_valid  data_in is valid
//   load_ready  serializer accepts a word this cycle
//   serial_out  serial bit stream (IDLE_BIT when no frame bit is valid)
//   bit_valid   serial_out carries a frame bit
//   busy        high whenever the FSM is not IDLE
//   frame_done  one-cycle pulse while the last bit of a frame is on serial_out
//   frames_sent completed-frame count, wraps modulo 2**CNT_W
// -----------------------------------------------------------------------------
module piso_bit_serializer #(
   parameter int   WIDTH      = 8,
   parameter int   MSB_FIRST  = 1,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_BIT   = 1'b0,
   parameter int   CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] frames_sent
);

   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BW-1:0] LAST_IDX   = BW'(WIDTH - 1);
   localparam logic [BW-1:0] PENULT_IDX = BW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift_reg;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;

   logic             last_bit;
   logic             accept;
   logic             load_bit;
   logic [WIDTH-1:0] load_rest;
   logic             next_bit;
   logic [WIDTH-1:0] next_rest;

   assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_IDX);
   assign load_ready = (state == IDLE) || (last_bit && (GAP_CYCLES == 0));
   assign accept     = load_valid && load_ready;
   assign busy       = (state != IDLE);

   // The shift register holds the bits still to be sent, with the next one
   // always at the transmit end, so the output mux is a single fixed tap.
   assign load_bit  = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
   assign load_rest = (MSB_FIRST != 0) ? (data_in << 1) : (data_in >> 1);
   assign next_bit  = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
   assign next_rest = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         serial_out  <= IDLE_BIT;
         bit_valid   <= 1'b0;
         frame_done  <= 1'b0;
         frames_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= SHIFT;
                  serial_out <= load_bit;
                  shift_reg  <= load_rest;
                  bit_cnt    <= '0;
                  bit_valid  <= 1'b1;
                  frame_done <= 1'b0;
               end
            end

            SHIFT: begin
               if (bit_cnt != LAST_IDX) begin
                  serial_out <= next_bit;
                  shift_reg  <= next_rest;
                  bit_cnt    <= bit_cnt + BW'(1);
                  // Registered so the pulse lines up with the last bit.
                  frame_done <= (bit_cnt == PENULT_IDX);
               end else begin
                  frames_sent <= frames_sent + CNT_W'(1);
                  frame_done  <= 1'b0;
                  if (GAP_CYCLES > 1) begin
                     // The IDLE cycle that follows GAP is itself one idle
                     // cycle, so GAP lasts GAP_CYCLES-1 cycles and the line
                     // stays quiet for exactly GAP_CYCLES cycles between
                     // back-to-back frames.
                     state      <= GAP;
                     gap_cnt    <= GW'(1);
                     serial_out <= IDLE_BIT;
                     bit_valid  <= 1'b0;
                  end else if (accept) begin
                     // Back-to-back: next frame's first bit, no bubble.
                     serial_out <= load_bit;
                     shift_reg  <= load_rest;
                     bit_cnt    <= '0;
                     bit_valid  <= 1'b1;
                  end else begin
                     // Also covers GAP_CYCLES==1: the IDLE cycle is the gap.
                     state      <= IDLE;
                     serial_out <= IDLE_BIT;
                     bit_valid  <= 1'b0;
                  end
               end
            end

            GAP: begin
               if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            default: begin
               state      <= IDLE;
               serial_out <= IDLE_BIT;
               bit_valid  <= 1'b0;
               frame_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
